// File: rtl/sd_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the SD-card SPI subsystem: bus owners, arbiter states
// and the command framing constants used by the SD engines.
package sd_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_WR   = 2'd2,
    OWN_RD   = 2'd3
  } owner_e;

  typedef enum logic [4:0] {
    ST_INIT      = 5'b00001,
    ST_IDLE      = 5'b00010,
    ST_WAIT_BUSY = 5'b00100,
    ST_RUN       = 5'b01000,
    ST_GAP       = 5'b10000
  } state_e;

  // Every SD command is 6 bytes: 01 + 6-bit index, 32-bit argument, CRC7 + stop bit.
  localparam logic [7:0] CMD_START_BITS     = 8'h40;
  localparam logic [7:0] CMD_STOP_BIT       = 8'h01;
  localparam int         CMD_FRAME_BYTES    = 6;
  localparam logic [5:0] CMD17_READ_SINGLE  = 6'd17;
  localparam logic [5:0] CMD24_WRITE_SINGLE = 6'd24;

  function automatic logic [7:0] cmd_byte(input logic [5:0] idx);
    return CMD_START_BITS | {2'b00, idx};
  endfunction

endpackage

// File: rtl/sd_bus_arbiter_if.sv
`timescale 1ns/1ps
// Signal bundle between the SD bus arbiter, the user request logic, the three
// SD engines and the card pins. The arbiter uses the master view.
interface sd_bus_arbiter_if;
  import sd_pkg::*;

  logic        sd_init_done;
  logic        init_cs;
  logic        init_mosi;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        wr_busy;
  logic        rd_busy;
  logic        wr_cs;
  logic        wr_mosi;
  logic        rd_cs;
  logic        rd_mosi;
  logic        sd_cs;
  logic        sd_mosi;
  logic        wr_go;
  logic        rd_go;
  logic [31:0] wr_go_addr;
  logic [31:0] rd_go_addr;
  owner_e      bus_owner;
  logic        sd_busy;
  logic        timeout_err;

  modport master (
    input  sd_init_done, init_cs, init_mosi,
    input  wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr,
    input  wr_busy, rd_busy, wr_cs, wr_mosi, rd_cs, rd_mosi,
    output sd_cs, sd_mosi, wr_go, rd_go, wr_go_addr, rd_go_addr,
    output bus_owner, sd_busy, timeout_err
  );

  modport slave (
    output sd_init_done, init_cs, init_mosi,
    output wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr,
    output wr_busy, rd_busy, wr_cs, wr_mosi, rd_cs, rd_mosi,
    input  sd_cs, sd_mosi, wr_go, rd_go, wr_go_addr, rd_go_addr,
    input  bus_owner, sd_busy, timeout_err
  );

endinterface

// File: rtl/sd_req_latch.sv
`timescale 1ns/1ps
// One pending sector request: a flag plus the address captured with the first
// start pulse. A pulse coinciding with a consume re-arms the flag.
module sd_req_latch (
  input  logic        clk_ref_180deg,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        start_en,
  input  logic [31:0] sec_addr,
  input  logic        consume,
  output logic        pending,
  output logic [31:0] addr
);

  logic        pending_q, pending_d;
  logic [31:0] addr_q, addr_d;

  always_comb begin
    pending_d = pending_q;
    addr_d    = addr_q;
    if (clr) begin
      pending_d = 1'b0;
    end else if (start_en && (!pending_q || consume)) begin
      pending_d = 1'b1;
      addr_d    = sec_addr;
    end else if (consume) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= 32'd0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign pending = pending_q;
  assign addr    = addr_q;

endmodule

// File: rtl/sd_bus_arbiter.sv
`timescale 1ns/1ps
// Owns the SD SPI lines: sd_init first, then round-robin sector write/read
// transfers with busy-handshake supervision and an idle gap after each one.
module sd_bus_arbiter
  import sd_pkg::*;
#(
  parameter logic [7:0]  BUSY_WAIT   = 8'd16,
  parameter logic [23:0] RUN_TIMEOUT = 24'd5_000_000,
  parameter logic [3:0]  GAP_CYCLES  = 4'd8
) (
  input  logic               clk_ref_180deg,
  input  logic               rst_n,
  sd_bus_arbiter_if.master   bus
);

  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;
  localparam logic [23:0] BW_LAST  = {16'd0, BUSY_WAIT} - 24'd1;
  localparam logic [23:0] RT_LAST  = RUN_TIMEOUT - 24'd1;
  localparam logic [23:0] GAP_LAST = {20'd0, GAP_CYCLES} - 24'd1;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [23:0] cnt_q, cnt_d;
  logic        wr_go_q, wr_go_d;
  logic        rd_go_q, rd_go_d;
  logic [31:0] wr_go_addr_q, wr_go_addr_d;
  logic [31:0] rd_go_addr_q, rd_go_addr_d;
  logic        last_rd_q, last_rd_d;
  logic        timeout_q, timeout_d;

  logic             reinit;
  logic             owner_busy;
  logic [1:0]       req_start;
  logic [1:0]       req_consume;
  logic [1:0]       req_pending;
  logic [1:0][31:0] req_sec_addr;
  logic [1:0][31:0] req_addr;

  assign req_start[REQ_WR]    = bus.wr_start_en;
  assign req_start[REQ_RD]    = bus.rd_start_en;
  assign req_sec_addr[REQ_WR] = bus.wr_sec_addr;
  assign req_sec_addr[REQ_RD] = bus.rd_sec_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      sd_req_latch u_req (
        .clk_ref_180deg (clk_ref_180deg),
        .rst_n          (rst_n),
        .clr            (reinit),
        .start_en       (req_start[gi]),
        .sec_addr       (req_sec_addr[gi]),
        .consume        (req_consume[gi]),
        .pending        (req_pending[gi]),
        .addr           (req_addr[gi])
      );
    end
  endgenerate

  assign owner_busy = (owner_q == OWN_RD) ? bus.rd_busy : bus.wr_busy;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    wr_go_d      = 1'b0;
    rd_go_d      = 1'b0;
    wr_go_addr_d = wr_go_addr_q;
    rd_go_addr_d = rd_go_addr_q;
    last_rd_d    = last_rd_q;
    timeout_d    = 1'b0;
    req_consume  = 2'b00;
    reinit       = 1'b0;

    // Losing init_done drops everything in flight; the card must be re-initialised.
    if (state_q != ST_INIT && !bus.sd_init_done) begin
      reinit  = 1'b1;
      state_d = ST_INIT;
      owner_d = OWN_INIT;
      cnt_d   = 24'd0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (bus.sd_init_done) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
          end
        end
        ST_IDLE: begin
          cnt_d = 24'd0;
          if (req_pending[REQ_WR] && (!req_pending[REQ_RD] || last_rd_q)) begin
            wr_go_d             = 1'b1;
            wr_go_addr_d        = req_addr[REQ_WR];
            req_consume[REQ_WR] = 1'b1;
            owner_d             = OWN_WR;
            last_rd_d           = 1'b0;
            state_d             = ST_WAIT_BUSY;
          end else if (req_pending[REQ_RD]) begin
            rd_go_d             = 1'b1;
            rd_go_addr_d        = req_addr[REQ_RD];
            req_consume[REQ_RD] = 1'b1;
            owner_d             = OWN_RD;
            last_rd_d           = 1'b1;
            state_d             = ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (owner_busy) begin
            state_d = ST_RUN;
            cnt_d   = 24'd0;
          end else if (cnt_q >= BW_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_GAP;
            owner_d   = OWN_NONE;
            cnt_d     = 24'd0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        ST_RUN: begin
          if (!owner_busy) begin
            state_d = ST_GAP;
            owner_d = OWN_NONE;
            cnt_d   = 24'd0;
          end else if (cnt_q >= RT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_GAP;
            owner_d   = OWN_NONE;
            cnt_d     = 24'd0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q >= GAP_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 24'd0;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        default: begin
          state_d = ST_INIT;
          owner_d = OWN_INIT;
          cnt_d   = 24'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      owner_q      <= OWN_INIT;
      cnt_q        <= 24'd0;
      wr_go_q      <= 1'b0;
      rd_go_q      <= 1'b0;
      wr_go_addr_q <= 32'd0;
      rd_go_addr_q <= 32'd0;
      last_rd_q    <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      wr_go_q      <= wr_go_d;
      rd_go_q      <= rd_go_d;
      wr_go_addr_q <= wr_go_addr_d;
      rd_go_addr_q <= rd_go_addr_d;
      last_rd_q    <= last_rd_d;
      timeout_q    <= timeout_d;
    end
  end

  // Pin mux decodes the owner register directly so engine bit timing is untouched.
  always_comb begin
    bus.sd_cs   = 1'b1;
    bus.sd_mosi = 1'b1;
    case (owner_q)
      OWN_INIT: begin
        bus.sd_cs   = bus.init_cs;
        bus.sd_mosi = bus.init_mosi;
      end
      OWN_WR: begin
        bus.sd_cs   = bus.wr_cs;
        bus.sd_mosi = bus.wr_mosi;
      end
      OWN_RD: begin
        bus.sd_cs   = bus.rd_cs;
        bus.sd_mosi = bus.rd_mosi;
      end
      default: begin
        bus.sd_cs   = 1'b1;
        bus.sd_mosi = 1'b1;
      end
    endcase
  end

  assign bus.wr_go       = wr_go_q;
  assign bus.rd_go       = rd_go_q;
  assign bus.wr_go_addr  = wr_go_addr_q;
  assign bus.rd_go_addr  = rd_go_addr_q;
  assign bus.bus_owner   = owner_q;
  assign bus.timeout_err = timeout_q;
  assign bus.sd_busy     = (state_q != ST_IDLE) || (|req_pending);

endmodule

// File: doc/sd_bus_arbiter.md
Name: sd_bus_arbiter

Overview:
- Owns the shared SD-card SPI lines (sd_cs, sd_mosi) after power-up and sequences sector-level access to the card.
- Hands the bus to sd_init until initialisation completes. Afterwards, grants it alternately to the sector-write and sector-read engines.
- Latches one pending request per requester, issues a one-cycle start pulse to the chosen engine, and supervises the engine's busy handshake with timeouts.
- Enforces an idle inter-command gap. Sits between the user request logic, the three SD engines and the card pins.

Parameters:
BUSY_WAIT, 8'd16, max cycles from go pulse to engine busy rising before the transfer is aborted
RUN_TIMEOUT, 24'd5_000_000, max cycles an engine may hold busy before the transfer is aborted
GAP_CYCLES, 4'd8, idle cycles (cs=1, mosi=1) inserted after every transfer

Ports:
clk_ref_180deg  in  1  clock; same clock as the SD engines' response sampling
rst_n  in  1  reset, asynchronous, active-low
sd_init_done  in  1  level from sd_init
init_cs / init_mosi  in  1/1  SPI lines driven by sd_init
wr_start_en  in  1  one-cycle write request pulse
wr_sec_addr  in  32  sector address, sampled with wr_start_en
rd_start_en  in  1  one-cycle read request pulse
rd_sec_addr  in  32  sector address, sampled with rd_start_en
wr_busy / rd_busy  in  1/1  busy levels from the write and read engines
wr_cs / wr_mosi / rd_cs / rd_mosi  in  1 each  SPI lines from the write and read engines
sd_cs / sd_mosi  out  1/1  muxed SPI lines to the card
wr_go / rd_go  out  1/1  one-cycle start pulses to the engines
wr_go_addr / rd_go_addr  out  32/32  address presented with the matching go pulse; held until the next go
bus_owner  out  2  0=none, 1=init, 2=write, 3=read
sd_busy  out  1  high whenever state is not IDLE or a request is pending
timeout_err  out  1  one-cycle pulse on any abort

Behaviour:
- Reset values: state=INIT, bus_owner=1, wr_go=rd_go=0, go_addr=0, pendings=0, last_grant=read, timeout_err=0, counters=0.
- Output mux is combinational from the bus_owner register, so engine bit timing passes through with zero latency:
  - owner 1 selects init lines.
  - owner 2 selects wr lines.
  - owner 3 selects rd lines.
  - owner 0 drives cs=1, mosi=1.
- Request latching:
  - A start pulse sets its pending flag and captures the address.
  - A pulse arriving while that requester's flag is already set is ignored; first address wins.
  - A pulse arriving in the same cycle its pending flag is consumed by a grant is latched as a new pending.
  - Pulses are accepted in every state, including INIT.
- FSM:
  - INIT: owner=1. Leave to IDLE (owner=0) in the cycle after sd_init_done is sampled high.
  - IDLE: if no request is pending, stay. If exactly one is pending, grant it. If both are pending, grant the requester opposite last_grant (round-robin). On grant:
    - pulse the go output for 1 cycle and present the address on go_addr;
    - clear that pending flag;
    - set owner and last_grant;
    - go to WAIT_BUSY.
  - WAIT_BUSY: count cycles. When the owner's busy is seen high, go to RUN and clear the counter. If the count reaches BUSY_WAIT-1 first, pulse timeout_err and go to GAP.
  - RUN: when the owner's busy is seen low, go to GAP. If busy is still high after RUN_TIMEOUT-1 cycles, pulse timeout_err and go to GAP.
  - GAP: owner=0. Count GAP_CYCLES, then go to IDLE.
- Re-init: sd_init_done sampled low in any non-INIT state forces INIT next cycle, with owner=1. Pending flags are cleared, counters are cleared, and no timeout_err is pulsed. Any engine go already issued is abandoned.
- Go pulses are never issued while sd_init_done=0.
- Counters saturate at their terminal values; they never wrap.

Decomposition:
- Shared package sd_pkg holds:
  - owner encodings OWN_NONE/INIT/WR/RD;
  - state encodings (one-hot, 5 states);
  - the CMD framing constants already common to the SD engines.
- One natural sub-module: sd_req_latch, a pending flag plus 32-bit address register with set/consume logic. It is instantiated twice (write and read).

Test Plan:
- Reset, then sd_init_done=1 after 100 cycles -> owner=1 and sd_cs=init_cs throughout INIT; owner=0 with sd_cs=1, sd_mosi=1 two cycles after the done edge.
- Single rd_start_en with addr 0x0000_1234, rd_busy rising 3 cycles after rd_go and held 40 cycles -> exactly one rd_go pulse with rd_go_addr=0x1234; sd_mosi tracks rd_mosi during RUN; 8 gap cycles; back to IDLE.
- wr_start_en and rd_start_en in the same cycle, with last_grant=read after reset -> write is granted first and read after the gap; a second wr pulse while write is pending is ignored (address unchanged).
- rd_go issued with rd_busy never rising -> timeout_err pulses 16 cycles after rd_go; no rd_go retry; returns to IDLE after the gap.
- rd_busy held high indefinitely (RUN_TIMEOUT overridden to 100) -> timeout_err at cycle 100 of RUN; owner goes to 0.
- sd_init_done dropped mid-RUN with a write pending -> next cycle state=INIT, owner=1, pending cleared, no timeout_err pulse.
